// File: rtl/quad_enc_ctrl.sv
// Quadrature detent controller for the PmodENC path.
// Syncs and filters A/B, tracks detents, and owns the position, LEDs and error count.
module quad_enc_ctrl #(
  parameter int POS_MAX    = 19,
  parameter int POS_W      = 5,
  parameter int GLITCH_CYC = 4
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             btn_in,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic [1:0]       led,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    ST_00 = 2'b00,
    ST_10 = 2'b10,
    ST_11 = 2'b11,
    ST_01 = 2'b01
  } ab_e;

  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
  localparam logic [7:0]       GCNT = 8'(GLITCH_CYC);

  // Maps the Gray-coded A/B pair onto its position in the CW cycle.
  function automatic logic [1:0] idx(input logic [1:0] v);
    return {v[0], v[1] ^ v[0]};
  endfunction

  logic             a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic             b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic             btn_prev_q, btn_prev_d;
  logic             btn_edge_q, btn_edge_d;
  logic [1:0]       s;
  logic [1:0]       s_prev_q, s_prev_d;
  ab_e              f_q, f_d, f_old_q, f_old_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             init_q, init_d;
  logic             upd_q, upd_d;
  logic             fupd;
  logic signed [3:0] acc_q, acc_d;
  logic signed [3:0] delta, sum;
  logic [1:0]       diff;
  logic             fwd, rev, ill;
  logic             cw_hit, ccw_hit;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [1:0]       led_q, led_d;
  logic [7:0]       err_q, err_d;

  // Input synchronizers, button edge detect and the A/B stability filter.
  always_comb begin
    a_s1_d     = a_in;
    a_s2_d     = a_s1_q;
    b_s1_d     = b_in;
    b_s2_d     = b_s1_q;
    btn_s1_d   = btn_in;
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    btn_edge_d = btn_s2_q & ~btn_prev_q;
    s          = {a_s2_q, b_s2_q};
    s_prev_d   = s;
    f_d        = f_q;
    cnt_d      = cnt_q;
    fupd       = 1'b0;
    // s_prev_q is the value that was counted stable, so it is what gets taken.
    if (cnt_q == GCNT) begin
      f_d   = ab_e'(s_prev_q);
      cnt_d = '0;
      fupd  = 1'b1;
    end else if (s == f_q) begin
      cnt_d = '0;
    end else if (s == s_prev_q) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
    f_old_d = fupd ? f_q : f_old_q;
    upd_d   = fupd & ~init_q;
    init_d  = init_q & ~fupd;
  end

  // Classify the last f move and run the detent accumulator.
  always_comb begin
    diff    = idx(f_q) - idx(f_old_q);
    fwd     = upd_q && (diff == 2'd1);
    rev     = upd_q && (diff == 2'd3);
    ill     = upd_q && (diff == 2'd2);
    delta   = fwd ? 4'sd1 : -4'sd1;
    sum     = acc_q + delta;
    acc_d   = acc_q;
    err_d   = err_q;
    cw_hit  = 1'b0;
    ccw_hit = 1'b0;
    unique case (1'b1)
      ill: begin
        acc_d = '0;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      fwd, rev: begin
        if (f_q == ST_00) begin
          acc_d   = '0;
          cw_hit  = (sum == 4'sd4);
          ccw_hit = (sum == -4'sd4);
        end else begin
          acc_d = sum;
        end
      end
      default: ;
    endcase
    if (btn_edge_q) acc_d = '0;
  end

  // Position, direction and LED update; a button clear overrides the step.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    led_d  = led_q;
    step_d = cw_hit | ccw_hit;
    if (cw_hit) begin
      pos_d = (pos_q == PMAX) ? '0 : pos_q + 1'b1;
      dir_d = 1'b1;
      led_d = 2'b01;
    end else if (ccw_hit) begin
      pos_d = (pos_q == '0) ? PMAX : pos_q - 1'b1;
      dir_d = 1'b0;
      led_d = 2'b10;
    end
    if (btn_edge_q) pos_d = '0;
  end

  // All state registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      a_s1_q     <= 1'b0;
      a_s2_q     <= 1'b0;
      b_s1_q     <= 1'b0;
      b_s2_q     <= 1'b0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      btn_edge_q <= 1'b0;
      s_prev_q   <= 2'b00;
      f_q        <= ST_00;
      f_old_q    <= ST_00;
      cnt_q      <= '0;
      init_q     <= 1'b1;
      upd_q      <= 1'b0;
      acc_q      <= '0;
      pos_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      led_q      <= 2'b00;
      err_q      <= '0;
    end else begin
      a_s1_q     <= a_s1_d;
      a_s2_q     <= a_s2_d;
      b_s1_q     <= b_s1_d;
      b_s2_q     <= b_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      btn_edge_q <= btn_edge_d;
      s_prev_q   <= s_prev_d;
      f_q        <= f_d;
      f_old_q    <= f_old_d;
      cnt_q      <= cnt_d;
      init_q     <= init_d;
      upd_q      <= upd_d;
      acc_q      <= acc_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      err_q      <= err_d;
    end
  end

  assign pos     = pos_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign led     = led_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// Bench for quad_enc_ctrl: directed scenarios plus random A/B/button traffic
// checked against a detent-level reference model.
module tb_quad_enc_ctrl;
  localparam int POS_MAX = 19;
  localparam int POS_W   = 5;
  localparam int G       = 4;
  localparam int HOLD    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             a, b, btn;
  logic [POS_W-1:0] pos;
  logic             step, dir;
  logic [1:0]       led;
  logic [7:0]       err_cnt;

  int nvec = 0;
  int nerr = 0;
  int steps_seen = 0;

  // Reference model state.
  logic [1:0] m_f;
  bit         m_init;
  int         m_acc, m_pos, m_dir, m_led, m_err, m_steps = 0;
  int         ord[4] = '{0, 2, 3, 1};

  quad_enc_ctrl #(.POS_MAX(POS_MAX), .POS_W(POS_W), .GLITCH_CYC(G)) dut (
    .clk_100MHz(clk), .reset(rst), .a_in(a), .b_in(b), .btn_in(btn),
    .pos(pos), .step(step), .dir(dir), .led(led), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) steps_seen++;

  task automatic m_reset();
    m_f = 2'b00; m_init = 1; m_acc = 0;
    m_pos = 0; m_dir = 0; m_led = 0; m_err = 0;
  endtask

  // Detent-level rule: position in the CW cycle decides the move.
  task automatic m_accept(input logic [1:0] v);
    int oi, ni, d, sum;
    if (v == m_f) return;
    if (m_init) begin m_f = v; m_init = 0; return; end
    oi = 0; ni = 0;
    for (int i = 0; i < 4; i++) begin
      if (ord[i] == int'(m_f)) oi = i;
      if (ord[i] == int'(v)) ni = i;
    end
    d = (ni - oi + 4) % 4;
    m_f = v;
    if (d == 2) begin
      m_acc = 0;
      if (m_err < 255) m_err++;
    end else begin
      sum = m_acc + ((d == 1) ? 1 : -1);
      if (v == 2'b00) begin
        if (sum == 4) begin
          m_pos = (m_pos == POS_MAX) ? 0 : m_pos + 1;
          m_dir = 1; m_led = 1; m_steps++;
        end else if (sum == -4) begin
          m_pos = (m_pos == 0) ? POS_MAX : m_pos - 1;
          m_dir = 0; m_led = 2; m_steps++;
        end
        m_acc = 0;
      end else m_acc = sum;
    end
  endtask

  task automatic m_button();
    m_pos = 0; m_acc = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input logic [1:0] v);
    a = v[1]; b = v[0];
  endtask

  task automatic apply_seg(input logic [1:0] v, input int hold);
    drv(v); m_accept(v); wait_cyc(hold);
  endtask

  task automatic seq_cw();
    apply_seg(2'b10, HOLD); apply_seg(2'b11, HOLD);
    apply_seg(2'b01, HOLD); apply_seg(2'b00, HOLD);
  endtask

  task automatic seq_ccw();
    apply_seg(2'b01, HOLD); apply_seg(2'b11, HOLD);
    apply_seg(2'b10, HOLD); apply_seg(2'b00, HOLD);
  endtask

  task automatic press();
    btn = 1; wait_cyc(5); m_button(); btn = 0; wait_cyc(3);
  endtask

  task automatic test_reset();
    rst = 1; btn = 0; drv(2'b11); m_reset();
    wait_cyc(3);
    nvec++; if (pos !== 0) begin nerr++; $display("FAIL rst_pos: got %0d want 0", pos); end
    nvec++; if (step !== 0) begin nerr++; $display("FAIL rst_step: got %b want 0", step); end
    nvec++; if (dir !== 0) begin nerr++; $display("FAIL rst_dir: got %b want 0", dir); end
    nvec++; if (led !== 0) begin nerr++; $display("FAIL rst_led: got %b want 00", led); end
    nvec++; if (err_cnt !== 0) begin nerr++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
    rst = 0; m_accept(2'b11); wait_cyc(12);
    nvec++; if (err_cnt !== m_err) begin nerr++; $display("FAIL init_err: got %0d want %0d", err_cnt, m_err); end
    nvec++; if (steps_seen !== m_steps) begin nerr++; $display("FAIL init_steps: got %0d want %0d", steps_seen, m_steps); end
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL init_pos: got %0d want %0d", pos, m_pos); end
  endtask

  task automatic test_cw_detent();
    apply_seg(2'b01, HOLD); apply_seg(2'b00, HOLD);
    nvec++; if (steps_seen !== m_steps) begin nerr++; $display("FAIL cw_pre_steps: got %0d want %0d", steps_seen, m_steps); end
    apply_seg(2'b10, HOLD); apply_seg(2'b11, HOLD); apply_seg(2'b01, HOLD);
    drv(2'b00); m_accept(2'b00);
    wait_cyc(7);
    nvec++; if (step !== 0) begin nerr++; $display("FAIL cw_step_early: got %b want 0", step); end
    wait_cyc(1);
    nvec++; if (step !== 1) begin nerr++; $display("FAIL cw_step_on: got %b want 1", step); end
    wait_cyc(1);
    nvec++; if (step !== 0) begin nerr++; $display("FAIL cw_step_off: got %b want 0", step); end
    wait_cyc(2);
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL cw_pos: got %0d want %0d", pos, m_pos); end
    nvec++; if (dir !== m_dir) begin nerr++; $display("FAIL cw_dir: got %b want %0d", dir, m_dir); end
    nvec++; if (led !== m_led) begin nerr++; $display("FAIL cw_led: got %b want %0d", led, m_led); end
    nvec++; if (steps_seen !== m_steps) begin nerr++; $display("FAIL cw_steps: got %0d want %0d", steps_seen, m_steps); end
  endtask

  task automatic test_wraps();
    seq_ccw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL ccw1_pos: got %0d want %0d", pos, m_pos); end
    seq_ccw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL ccw_wrap_pos: got %0d want %0d", pos, m_pos); end
    nvec++; if (led !== m_led) begin nerr++; $display("FAIL ccw_wrap_led: got %b want %0d", led, m_led); end
    nvec++; if (dir !== m_dir) begin nerr++; $display("FAIL ccw_wrap_dir: got %b want %0d", dir, m_dir); end
    seq_cw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL cw_wrap_pos: got %0d want %0d", pos, m_pos); end
    nvec++; if (led !== m_led) begin nerr++; $display("FAIL cw_wrap_led: got %b want %0d", led, m_led); end
  endtask

  task automatic test_bounce_glitch();
    int p0 = int'(pos);
    int s0 = steps_seen;
    for (int i = 0; i < 5; i++) begin
      apply_seg(2'b10, HOLD); apply_seg(2'b00, HOLD);
    end
    nvec++; if (int'(pos) !== p0) begin nerr++; $display("FAIL bounce_pos: got %0d want %0d", pos, p0); end
    nvec++; if (steps_seen !== s0) begin nerr++; $display("FAIL bounce_steps: got %0d want %0d", steps_seen, s0); end
    drv(2'b10); wait_cyc(G - 1); drv(2'b00); wait_cyc(HOLD);
    drv(2'b11); wait_cyc(G - 1); drv(2'b00); wait_cyc(HOLD);
    nvec++; if (err_cnt !== m_err) begin nerr++; $display("FAIL glitch_err: got %0d want %0d", err_cnt, m_err); end
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL glitch_pos: got %0d want %0d", pos, m_pos); end
    seq_cw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL glitch_cw_pos: got %0d want %0d", pos, m_pos); end
  endtask

  task automatic test_illegal();
    int s0 = steps_seen;
    apply_seg(2'b11, HOLD);
    nvec++; if (err_cnt !== m_err) begin nerr++; $display("FAIL ill_err: got %0d want %0d", err_cnt, m_err); end
    nvec++; if (steps_seen !== s0) begin nerr++; $display("FAIL ill_steps: got %0d want %0d", steps_seen, s0); end
    for (int i = 0; i < 299; i++) apply_seg((i % 2 == 0) ? 2'b00 : 2'b11, HOLD);
    nvec++; if (err_cnt !== m_err) begin nerr++; $display("FAIL ill_sat: got %0d want %0d", err_cnt, m_err); end
    seq_cw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL ill_cw_pos: got %0d want %0d", pos, m_pos); end
  endtask

  task automatic test_button();
    press();
    for (int i = 0; i < 7; i++) seq_cw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL btn_pre_pos: got %0d want %0d", pos, m_pos); end
    btn = 1; wait_cyc(3);
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL btn_early: got %0d want %0d", pos, m_pos); end
    wait_cyc(1); m_button();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL btn_clear: got %0d want %0d", pos, m_pos); end
    seq_cw();
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL btn_held: got %0d want %0d", pos, m_pos); end
    btn = 0; wait_cyc(3);
    nvec++; if (dir !== m_dir) begin nerr++; $display("FAIL btn_dir: got %b want %0d", dir, m_dir); end
    nvec++; if (led !== m_led) begin nerr++; $display("FAIL btn_led: got %b want %0d", led, m_led); end
  endtask

  task automatic test_btn_coincident();
    seq_cw(); seq_cw();
    apply_seg(2'b10, HOLD); apply_seg(2'b11, HOLD); apply_seg(2'b01, HOLD);
    drv(2'b00); m_accept(2'b00);
    wait_cyc(4); btn = 1;
    wait_cyc(4); m_button();
    nvec++; if (step !== 1) begin nerr++; $display("FAIL coin_step: got %b want 1", step); end
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL coin_pos: got %0d want %0d", pos, m_pos); end
    wait_cyc(2); btn = 0; wait_cyc(3);
    nvec++; if (led !== m_led) begin nerr++; $display("FAIL coin_led: got %b want %0d", led, m_led); end
    nvec++; if (steps_seen !== m_steps) begin nerr++; $display("FAIL coin_steps: got %0d want %0d", steps_seen, m_steps); end
  endtask

  task automatic test_reset_mid();
    seq_cw();
    apply_seg(2'b10, HOLD); apply_seg(2'b11, HOLD);
    rst = 1; m_reset(); wait_cyc(2);
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL mid_rst_pos: got %0d want %0d", pos, m_pos); end
    nvec++; if (err_cnt !== m_err) begin nerr++; $display("FAIL mid_rst_err: got %0d want %0d", err_cnt, m_err); end
    rst = 0;
    apply_seg(2'b11, 12); apply_seg(2'b01, HOLD); apply_seg(2'b00, HOLD);
    nvec++; if (steps_seen !== m_steps) begin nerr++; $display("FAIL mid_steps: got %0d want %0d", steps_seen, m_steps); end
    nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL mid_pos: got %0d want %0d", pos, m_pos); end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] g;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 11);
      if (r < 5) apply_seg(2'($urandom_range(0, 3)), $urandom_range(G + 4, G + 9));
      else if (r < 7) begin
        g = 2'($urandom_range(0, 3));
        if (g != m_f) begin
          drv(g); wait_cyc($urandom_range(1, G - 1)); drv(m_f); wait_cyc(HOLD);
        end
      end
      else if (r == 7) press();
      else if (r < 10) seq_cw();
      else seq_ccw();
      nvec++; if (pos !== m_pos) begin nerr++; $display("FAIL rnd_pos[%0d]: got %0d want %0d", it, pos, m_pos); end
      nvec++; if (dir !== m_dir) begin nerr++; $display("FAIL rnd_dir[%0d]: got %b want %0d", it, dir, m_dir); end
      nvec++; if (led !== m_led) begin nerr++; $display("FAIL rnd_led[%0d]: got %b want %0d", it, led, m_led); end
      nvec++; if (err_cnt !== m_err) begin nerr++; $display("FAIL rnd_err[%0d]: got %0d want %0d", it, err_cnt, m_err); end
      nvec++; if (steps_seen !== m_steps) begin nerr++; $display("FAIL rnd_steps[%0d]: got %0d want %0d", it, steps_seen, m_steps); end
    end
  endtask

  initial begin
    rst = 1; a = 0; b = 0; btn = 0;
    test_reset();
    test_cw_detent();
    test_wraps();
    test_bounce_glitch();
    test_illegal();
    test_button();
    test_btn_coincident();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
